// File: rtl/linear_pixel_capture.sv
// linear_pixel_capture
//
// Purpose:
//   Captures one frame of ADC samples from a linear image sensor. Each SI
//   pulse starts a capture. After ADC_LAT cycles, one sample per pixel is
//   written into a double-buffered frame memory. The brightest pixel (the
//   laser spot) is tracked while the frame is captured. The last completed
//   frame, its peak index and its peak value are presented to the
//   force-estimation logic.
//
// Ports:
//   sensor_clk  - single clock; all logic is on the rising edge
//   reset       - synchronous, active-high
//   si_pulse    - one-cycle start-integration pulse
//   adc_data    - unsigned pixel sample
//   rd_addr     - read address into the last completed frame
//   rd_data     - registered read data (one cycle after rd_addr)
//   frame_done  - one-cycle pulse when a frame completes
//   peak_index  - pixel index of the maximum in the last completed frame
//   peak_value  - maximum value in the last completed frame
//   frame_count - count of completed frames (wraps)
//   busy        - high while waiting on the ADC pipeline or capturing
//   overrun     - one-cycle pulse when si_pulse aborts a frame in progress
//
// Optional feature (macro PEAK_THRESHOLD_EN):
//   Adds the input peak_thresh and the output peak_valid. When the frame
//   completes, peak_valid shows whether the frame maximum reached the
//   threshold. The peak outputs only update when peak_valid is set.

module linear_pixel_capture #(
    parameter int NPIX    = 128,
    parameter int ADDR_W  = 7,
    parameter int ADC_W   = 12,
    parameter int ADC_LAT = 2,
    parameter int CNT_W   = 16
) (
    input  logic              sensor_clk,
    input  logic              reset,
    input  logic              si_pulse,
    input  logic [ADC_W-1:0]  adc_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [ADC_W-1:0]  rd_data,
    output logic              frame_done,
    output logic [ADDR_W-1:0] peak_index,
    output logic [ADC_W-1:0]  peak_value,
    output logic [CNT_W-1:0]  frame_count,
    output logic              busy,
    output logic              overrun
`ifdef PEAK_THRESHOLD_EN
    , input  logic [ADC_W-1:0] peak_thresh
    , output logic             peak_valid
`endif
);

    localparam int LAT_W = (ADC_LAT > 1) ? $clog2(ADC_LAT) : 1;
    localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(NPIX - 1);
    // Memory is addressed as {bank, pixel}, so each bank spans the full
    // pixel address range even when NPIX is not a power of two.
    localparam int DEPTH = 2 ** (ADDR_W + 1);

    typedef enum logic [1:0] {IDLE, WAIT, CAPTURE, DONE} state_t;

    state_t             state_q, state_d;
    logic [LAT_W-1:0]   lat_cnt_q, lat_cnt_d;
    logic [ADDR_W-1:0]  pix_q, pix_d;
    logic [ADC_W-1:0]   max_val_q, max_val_d;
    logic [ADDR_W-1:0]  max_idx_q, max_idx_d;
    logic               rd_bank_q, rd_bank_d;
    logic               frame_done_q, frame_done_d;
    logic [ADDR_W-1:0]  peak_index_q, peak_index_d;
    logic [ADC_W-1:0]   peak_value_q, peak_value_d;
    logic [CNT_W-1:0]   frame_count_q, frame_count_d;
    logic               busy_q, busy_d;
    logic               overrun_q, overrun_d;
    logic               start;
    logic               wr_en;
    logic [ADC_W-1:0]   rd_data_q;
`ifdef PEAK_THRESHOLD_EN
    logic               peak_valid_q, peak_valid_d;
`endif

    logic [ADC_W-1:0]   mem [DEPTH];

    // Next-state and next-output logic for the capture sequencer.
    always_comb begin
        state_d       = state_q;
        lat_cnt_d     = lat_cnt_q;
        pix_d         = pix_q;
        max_val_d     = max_val_q;
        max_idx_d     = max_idx_q;
        rd_bank_d     = rd_bank_q;
        frame_done_d  = 1'b0;
        peak_index_d  = peak_index_q;
        peak_value_d  = peak_value_q;
        frame_count_d = frame_count_q;
        overrun_d     = 1'b0;
        start         = 1'b0;
`ifdef PEAK_THRESHOLD_EN
        peak_valid_d  = peak_valid_q;
`endif

        case (state_q)
            IDLE: begin
                if (si_pulse) start = 1'b1;
            end
            WAIT: begin
                if (si_pulse) begin
                    start     = 1'b1;
                    overrun_d = 1'b1;
                end else if (int'(lat_cnt_q) == ADC_LAT - 1) begin
                    state_d = CAPTURE;
                    pix_d   = '0;
                end else begin
                    lat_cnt_d = lat_cnt_q + LAT_W'(1);
                end
            end
            CAPTURE: begin
                if (si_pulse) begin
                    start     = 1'b1;
                    overrun_d = 1'b1;
                end else begin
                    // Pixel 0 seeds the running maximum; later pixels must be
                    // strictly greater so the first of equal peaks is kept.
                    if (pix_q == '0 || adc_data > max_val_q) begin
                        max_val_d = adc_data;
                        max_idx_d = pix_q;
                    end
                    pix_d = pix_q + ADDR_W'(1);
                    if (pix_q == LAST_PIX) state_d = DONE;
                end
            end
            DONE: begin
                frame_done_d  = 1'b1;
                frame_count_d = frame_count_q + CNT_W'(1);
                rd_bank_d     = ~rd_bank_q;
`ifdef PEAK_THRESHOLD_EN
                peak_valid_d  = (max_val_q >= peak_thresh);
                if (peak_valid_d) begin
                    peak_index_d = max_idx_q;
                    peak_value_d = max_val_q;
                end
`else
                peak_index_d  = max_idx_q;
                peak_value_d  = max_val_q;
`endif
                state_d       = IDLE;
                // An SI landing here still lets this frame complete.
                if (si_pulse) start = 1'b1;
            end
        endcase

        // A new SI restarts capture with identical timing from any state.
        if (start) begin
            state_d   = (ADC_LAT == 0) ? CAPTURE : WAIT;
            lat_cnt_d = '0;
            pix_d     = '0;
        end

        busy_d = (state_d == WAIT) || (state_d == CAPTURE);
    end

    // State and registered outputs; reset wipes any partial frame.
    always_ff @(posedge sensor_clk) begin
        if (reset) begin
            state_q       <= IDLE;
            lat_cnt_q     <= '0;
            pix_q         <= '0;
            max_val_q     <= '0;
            max_idx_q     <= '0;
            rd_bank_q     <= 1'b1;
            frame_done_q  <= 1'b0;
            peak_index_q  <= '0;
            peak_value_q  <= '0;
            frame_count_q <= '0;
            busy_q        <= 1'b0;
            overrun_q     <= 1'b0;
`ifdef PEAK_THRESHOLD_EN
            peak_valid_q  <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            lat_cnt_q     <= lat_cnt_d;
            pix_q         <= pix_d;
            max_val_q     <= max_val_d;
            max_idx_q     <= max_idx_d;
            rd_bank_q     <= rd_bank_d;
            frame_done_q  <= frame_done_d;
            peak_index_q  <= peak_index_d;
            peak_value_q  <= peak_value_d;
            frame_count_q <= frame_count_d;
            busy_q        <= busy_d;
            overrun_q     <= overrun_d;
`ifdef PEAK_THRESHOLD_EN
            peak_valid_q  <= peak_valid_d;
`endif
        end
    end

    // The write bank is always the bank opposite the read bank.
    assign wr_en = (state_q == CAPTURE) && !si_pulse;

    // Frame memory: one write port and one registered read port. The read
    // uses the bank before any swap, so a read in the DONE cycle sees the
    // old frame.
    always_ff @(posedge sensor_clk) begin
        if (wr_en) mem[{~rd_bank_q, pix_q}] <= adc_data;
        if (reset) rd_data_q <= '0;
        else       rd_data_q <= mem[{rd_bank_q, rd_addr}];
    end

    assign rd_data     = rd_data_q;
    assign frame_done  = frame_done_q;
    assign peak_index  = peak_index_q;
    assign peak_value  = peak_value_q;
    assign frame_count = frame_count_q;
    assign busy        = busy_q;
    assign overrun     = overrun_q;
`ifdef PEAK_THRESHOLD_EN
    assign peak_valid  = peak_valid_q;
`endif

endmodule

// File: tb/tb_linear_pixel_capture.sv
// tb_linear_pixel_capture
//
// Drives two copies of linear_pixel_capture from the same stimulus: one
// with ADC_LAT=2 and one with ADC_LAT=0. A frame-level reference model
// tracks, for each copy, the number of edges since the accepted SI. From
// that it works out which pixel is sampled, when a frame completes, and
// when an SI aborts a capture. Every output is compared on every cycle.
// Optional feature macro: PEAK_THRESHOLD_EN.

module tb_linear_pixel_capture;

    localparam int NPIX   = 128;
    localparam int ADDR_W = 7;
    localparam int ADC_W  = 12;
    localparam int CNT_W  = 16;

    logic              sensor_clk = 1'b0;
    logic              reset;
    logic              si_pulse;
    logic [ADC_W-1:0]  adc_data;
    logic [ADDR_W-1:0] rd_addr;

    logic [ADC_W-1:0]  rd_data     [2];
    logic              frame_done  [2];
    logic [ADDR_W-1:0] peak_index  [2];
    logic [ADC_W-1:0]  peak_value  [2];
    logic [CNT_W-1:0]  frame_count [2];
    logic              busy        [2];
    logic              overrun     [2];
`ifdef PEAK_THRESHOLD_EN
    logic [ADC_W-1:0]  peak_thresh;
    logic              peak_valid  [2];
    logic              exp_pv      [2];
`endif

    // Reference model state, one entry per DUT copy.
    int                lat [2] = '{2, 0};
    int                since [2];
    logic [ADC_W-1:0]  cap  [2][NPIX];
    logic [ADC_W-1:0]  last [2][NPIX];
    bit                rd_valid [2];
    bit                rd_check [2];
    logic              exp_done [2];
    logic              exp_ov   [2];
    logic              exp_busy [2];
    logic [CNT_W-1:0]  exp_cnt  [2];
    logic [ADDR_W-1:0] exp_idx  [2];
    logic [ADC_W-1:0]  exp_val  [2];
    logic [ADC_W-1:0]  exp_rd   [2];

    int compared   = 0;
    int mismatched = 0;

    always #5 sensor_clk = ~sensor_clk;

    linear_pixel_capture #(.ADC_LAT(2)) dut_lat2 (
        .sensor_clk (sensor_clk),
        .reset      (reset),
        .si_pulse   (si_pulse),
        .adc_data   (adc_data),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data[0]),
        .frame_done (frame_done[0]),
        .peak_index (peak_index[0]),
        .peak_value (peak_value[0]),
        .frame_count(frame_count[0]),
        .busy       (busy[0]),
        .overrun    (overrun[0])
`ifdef PEAK_THRESHOLD_EN
        , .peak_thresh(peak_thresh)
        , .peak_valid (peak_valid[0])
`endif
    );

    linear_pixel_capture #(.ADC_LAT(0)) dut_lat0 (
        .sensor_clk (sensor_clk),
        .reset      (reset),
        .si_pulse   (si_pulse),
        .adc_data   (adc_data),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data[1]),
        .frame_done (frame_done[1]),
        .peak_index (peak_index[1]),
        .peak_value (peak_value[1]),
        .frame_count(frame_count[1]),
        .busy       (busy[1]),
        .overrun    (overrun[1])
`ifdef PEAK_THRESHOLD_EN
        , .peak_thresh(peak_thresh)
        , .peak_valid (peak_valid[1])
`endif
    );

    task automatic compareVal(input string tag, input int inst,
                              input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s dut%0d: observed %0h, expected %0h", tag, inst, obs, exp);
        end
    endtask

    // Frame completion: the captured frame becomes the readable frame and
    // its maximum (first occurrence) becomes the peak.
    task automatic completeFrame(input int i);
        logic [ADC_W-1:0] best;
        int where;
        best = '0;
        where = 0;
        for (int k = 0; k < NPIX; k++) if (cap[i][k] > best) best = cap[i][k];
        for (int k = 0; k < NPIX; k++) begin
            if (cap[i][k] == best) begin
                where = k;
                break;
            end
        end
        for (int k = 0; k < NPIX; k++) last[i][k] = cap[i][k];
        exp_done[i] = 1'b1;
        exp_cnt[i]  = exp_cnt[i] + CNT_W'(1);
        rd_valid[i] = 1'b1;
`ifdef PEAK_THRESHOLD_EN
        exp_pv[i] = (best >= peak_thresh);
        if (exp_pv[i]) begin
            exp_idx[i] = ADDR_W'(where);
            exp_val[i] = best;
        end
`else
        exp_idx[i] = ADDR_W'(where);
        exp_val[i] = best;
`endif
    endtask

    task automatic checkOutput();
        for (int i = 0; i < 2; i++) begin
            compareVal("frame_done",  i, 32'(frame_done[i]),  32'(exp_done[i]));
            compareVal("overrun",     i, 32'(overrun[i]),     32'(exp_ov[i]));
            compareVal("busy",        i, 32'(busy[i]),        32'(exp_busy[i]));
            compareVal("frame_count", i, 32'(frame_count[i]), 32'(exp_cnt[i]));
            compareVal("peak_index",  i, 32'(peak_index[i]),  32'(exp_idx[i]));
            compareVal("peak_value",  i, 32'(peak_value[i]),  32'(exp_val[i]));
            if (rd_check[i]) compareVal("rd_data", i, 32'(rd_data[i]), 32'(exp_rd[i]));
`ifdef PEAK_THRESHOLD_EN
            compareVal("peak_valid",  i, 32'(peak_valid[i]),  32'(exp_pv[i]));
`endif
        end
    endtask

    // One clock edge: drive inputs, advance the model, then check outputs
    // 1 time unit after the edge.
    task automatic applyStimulus(input logic si_in, input logic [ADC_W-1:0] adc_in,
                                 input logic [ADDR_W-1:0] addr_in, input logic rst_in);
        int k;
        si_pulse = si_in;
        adc_data = adc_in;
        rd_addr  = addr_in;
        reset    = rst_in;
        @(posedge sensor_clk);
        for (int i = 0; i < 2; i++) begin
            rd_check[i] = rd_valid[i];
            if (rd_valid[i]) exp_rd[i] = last[i][addr_in];
            exp_done[i] = 1'b0;
            exp_ov[i]   = 1'b0;
            if (rst_in) begin
                since[i]    = -1;
                exp_cnt[i]  = '0;
                exp_idx[i]  = '0;
                exp_val[i]  = '0;
                exp_rd[i]   = '0;
                rd_check[i] = 1'b1;
                rd_valid[i] = 1'b0;
`ifdef PEAK_THRESHOLD_EN
                exp_pv[i]   = 1'b0;
`endif
            end else if (since[i] < 0) begin
                since[i] = si_in ? 0 : -1;
            end else if (since[i] == lat[i] + NPIX) begin
                completeFrame(i);
                since[i] = si_in ? 0 : -1;
            end else if (si_in) begin
                exp_ov[i] = 1'b1;
                since[i]  = 0;
            end else begin
                since[i] = since[i] + 1;
                k = since[i] - 1 - lat[i];
                if (k >= 0 && k < NPIX) cap[i][k] = adc_in;
            end
            exp_busy[i] = (since[i] >= 0) && (since[i] < lat[i] + NPIX);
        end
        #1;
        checkOutput();
    endtask

    // Pixel k as seen by the ADC_LAT=2 copy. The ADC_LAT=0 copy sees the
    // same stream two pixels earlier.
    function automatic logic [ADC_W-1:0] pixelValue(input int kind, input int k);
        if (k < 0 || k >= NPIX) return ADC_W'($urandom_range(0, 4095));
        case (kind)
            0:       return ADC_W'(k);
            1:       return (k == 40 || k == 90) ? ADC_W'(4000) : ADC_W'(k);
            3:       return ADC_W'(100);
            4:       return (k == 64) ? ADC_W'(3500) : ADC_W'(100);
            default: return ADC_W'($urandom_range(0, 4095));
        endcase
    endfunction

    // SI on the first cycle, then pixel data for the rest.
    task automatic runCapture(input int kind, input int n_cycles);
        for (int c = 0; c < n_cycles; c++)
            applyStimulus(c == 0, pixelValue(kind, c - 3),
                          ADDR_W'($urandom_range(0, NPIX - 1)), 1'b0);
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            since[i]    = -1;
            rd_valid[i] = 1'b0;
            rd_check[i] = 1'b0;
            exp_cnt[i]  = '0;
            exp_idx[i]  = '0;
            exp_val[i]  = '0;
            exp_rd[i]   = '0;
`ifdef PEAK_THRESHOLD_EN
            exp_pv[i]   = 1'b0;
`endif
        end
`ifdef PEAK_THRESHOLD_EN
        peak_thresh = '0;
`endif
        $display("[TB] start");

        // Reset, then idle so the first SI lands at cycle 10.
        for (int c = 0; c < 3; c++) applyStimulus(1'b0, '0, '0, 1'b1);
        for (int c = 0; c < 6; c++) applyStimulus(1'b0, '0, '0, 1'b0);

        // Ramp frame: pixel value equals pixel index.
        runCapture(0, 134);
        compareVal("ramp_peak_index", 0, 32'(peak_index[0]), 32'd127);
        compareVal("ramp_peak_value", 0, 32'(peak_value[0]), 32'd127);
        compareVal("ramp_frame_count", 0, 32'(frame_count[0]), 32'd1);
        applyStimulus(1'b0, '0, ADDR_W'(5), 1'b0);
        compareVal("ramp_read5", 0, 32'(rd_data[0]), 32'd5);

        // Two equal spikes: the first one must win.
        runCapture(1, 134);
        compareVal("tie_peak_index", 0, 32'(peak_index[0]), 32'd40);
        compareVal("tie_peak_value", 0, 32'(peak_value[0]), 32'd4000);

        // Abort at pixel 60, then let the restarted frame complete.
        runCapture(2, 64);
        runCapture(2, 134);

        // SI every 129 cycles: lands in DONE for ADC_LAT=0 and aborts the
        // ADC_LAT=2 copy.
        for (int p = 0; p < 3; p++) runCapture(2, 129);
        runCapture(2, 134);

        // Reset in the middle of a capture, then capture normally.
        runCapture(2, 103);
        applyStimulus(1'b0, '0, '0, 1'b1);
        for (int c = 0; c < 4; c++) applyStimulus(1'b0, '0, '0, 1'b0);
        runCapture(0, 134);

`ifdef PEAK_THRESHOLD_EN
        peak_thresh = ADC_W'(3000);
        runCapture(3, 134);
        compareVal("thresh_flat_valid", 0, 32'(peak_valid[0]), 32'd0);
        compareVal("thresh_flat_value", 0, 32'(peak_value[0]), 32'd127);
        runCapture(4, 134);
        compareVal("thresh_spike_valid", 0, 32'(peak_valid[0]), 32'd1);
        compareVal("thresh_spike_value", 0, 32'(peak_value[0]), 32'd3500);
`else
        runCapture(3, 134);
        runCapture(4, 134);
        compareVal("spike_peak_value", 0, 32'(peak_value[0]), 32'd3500);
        compareVal("spike_peak_index", 0, 32'(peak_index[0]), 32'd64);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
